// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO and configurable data width, parity and stop bits.
// Frames leave back-to-back while words are queued; out idles high.
module uart_tx_fifo #(
    parameter int COUNT_WIDTH = 12,
    parameter logic [COUNT_WIDTH-1:0] COUNT_MAX = 12'd2603,
    parameter int DATA_BITS = 8,
    parameter int PARITY = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] in,
    input  logic                 valid,
    output logic                 ready,
    output logic                 out,
    output logic                 busy,
    output logic [FIFO_AW:0]     level
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                 state, state_n;
    logic [COUNT_WIDTH-1:0] cnt, cnt_n;
    logic [3:0]             bitn, bitn_n;
    logic [DATA_BITS-1:0]   shift, shift_n;
    logic                   par, par_n;

    logic [DATA_BITS-1:0]   mem [DEPTH];
    logic [FIFO_AW:0]       wptr, rptr;
    logic [DATA_BITS-1:0]   head;
    logic                   full, empty, push, pop, tick, head_par;

    assign empty = (wptr == rptr);
    assign full  = ((wptr ^ rptr) == {1'b1, {FIFO_AW{1'b0}}});
    assign push  = valid && !full;
    assign head  = mem[rptr[FIFO_AW-1:0]];
    assign tick  = (cnt == COUNT_MAX);
    assign ready = !full;
    assign busy  = (state != IDLE) || !empty;
    assign level = wptr - rptr;

    assign head_par = (PARITY == 1) ? ~^head : ^head;

    always_ff @(posedge CLK) begin
        if (push)
            mem[wptr[FIFO_AW-1:0]] <= in;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            bitn  <= '0;
            shift <= '0;
            par   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bitn  <= bitn_n;
            shift <= shift_n;
            par   <= par_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bitn_n  = bitn;
        shift_n = shift;
        par_n   = par;
        pop     = 1'b0;
        if (state != IDLE)
            cnt_n = tick ? '0 : cnt + 1'b1;
        case (state)
            IDLE: begin
                if (!empty)
                    pop = 1'b1;
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    bitn_n  = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_n = shift >> 1;
                    if (bitn == LAST_DATA) begin
                        state_n = (PARITY != 0) ? PAR : STOP;
                        bitn_n  = '0;
                    end else begin
                        bitn_n = bitn + 1'b1;
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    state_n = STOP;
                    bitn_n  = '0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bitn != LAST_STOP)
                        bitn_n = bitn + 1'b1;
                    else if (!empty)
                        pop = 1'b1;
                    else
                        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // A pop always starts a fresh frame, whether from idle or the last stop bit
        if (pop) begin
            state_n = START;
            cnt_n   = '0;
            bitn_n  = '0;
            shift_n = head;
            par_n   = head_par;
        end
    end

    always_comb begin
        out = 1'b1;
        case (state)
            START:   out = 1'b0;
            DATA:    out = shift[0];
            PAR:     out = par;
            default: out = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations against a queue-based line model,
// plus literal frame patterns for the directed cases.
module tb_uart_tx_fifo;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [3:0] v = '0;
    logic [3:0][8:0] d = '0;
    logic [3:0] o, rdy, bsy;
    logic [2:0] lv0;
    logic [4:0] lv1, lv2, lv3;

    int errs = 0;
    int checks = 0;

    int cm [4] = '{3, 3, 3, 3};
    int db [4] = '{8, 8, 8, 5};
    int pm [4] = '{0, 2, 1, 0};
    int sb [4] = '{1, 2, 2, 1};
    int dep[4] = '{4, 16, 16, 16};

    int unsigned fq[4][$];
    bit          wq[4][$];

    always #5 CLK = ~CLK;

    uart_tx_fifo #(.COUNT_MAX(12'd3), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_AW(2)) u0 (
        .CLK(CLK), .RST(RST), .in(d[0][7:0]), .valid(v[0]),
        .ready(rdy[0]), .out(o[0]), .busy(bsy[0]), .level(lv0));
    uart_tx_fifo #(.COUNT_MAX(12'd3), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(2), .FIFO_AW(4)) u1 (
        .CLK(CLK), .RST(RST), .in(d[1][7:0]), .valid(v[1]),
        .ready(rdy[1]), .out(o[1]), .busy(bsy[1]), .level(lv1));
    uart_tx_fifo #(.COUNT_MAX(12'd3), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(2), .FIFO_AW(4)) u2 (
        .CLK(CLK), .RST(RST), .in(d[2][7:0]), .valid(v[2]),
        .ready(rdy[2]), .out(o[2]), .busy(bsy[2]), .level(lv2));
    uart_tx_fifo #(.COUNT_MAX(12'd3), .DATA_BITS(5), .PARITY(0),
                   .STOP_BITS(1), .FIFO_AW(4)) u3 (
        .CLK(CLK), .RST(RST), .in(d[3][4:0]), .valid(v[3]),
        .ready(rdy[3]), .out(o[3]), .busy(bsy[3]), .level(lv3));

    function automatic int lvl(int k);
        case (k)
            0: return int'(lv0);
            1: return int'(lv1);
            2: return int'(lv2);
            default: return int'(lv3);
        endcase
    endfunction

    task automatic chk(input string nm, input int k,
                       input logic [15:0] act, input int exp);
        checks++;
        if (act !== 16'(exp)) begin
            errs++;
            $display("FAIL %s[%0d] got %0d want %0d at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Line model: each popped word becomes a list of per-cycle line levels
    task automatic load_frame(input int k, input int unsigned w);
        bit b[$];
        bit x;
        x = 1'b0;
        b.push_back(1'b0);
        for (int i = 0; i < db[k]; i++) begin
            b.push_back(w[i]);
            x ^= w[i];
        end
        if (pm[k] != 0)
            b.push_back(pm[k] == 2 ? x : !x);
        for (int i = 0; i < sb[k]; i++)
            b.push_back(1'b1);
        foreach (b[j])
            for (int c = 0; c <= cm[k]; c++)
                wq[k].push_back(b[j]);
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < 4; k++) begin
                fq[k].delete();
                wq[k].delete();
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                automatic bit full_pre = (fq[k].size() == dep[k]);
                if (wq[k].size() != 0)
                    void'(wq[k].pop_front());
                if (wq[k].size() == 0 && fq[k].size() != 0)
                    load_frame(k, fq[k].pop_front());
                if (v[k] && !full_pre)
                    fq[k].push_back(int'(d[k]) & ((1 << db[k]) - 1));
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            for (int k = 0; k < 4; k++) begin
                chk("out", k, 16'(o[k]), wq[k].size() != 0 ? int'(wq[k][0]) : 1);
                chk("ready", k, 16'(rdy[k]), fq[k].size() < dep[k] ? 1 : 0);
                chk("busy", k, 16'(bsy[k]),
                    (wq[k].size() != 0 || fq[k].size() != 0) ? 1 : 0);
                chk("level", k, 16'(lvl(k)), fq[k].size());
            end
        end
    end

    task automatic pin_frame(input int k, input int nw, input logic [8:0] w0,
                             input logic [8:0] w1, input logic [15:0] bits,
                             input int nbits);
        @(negedge CLK);
        d[k] = w0;
        v[k] = 1'b1;
        @(negedge CLK);
        chk("pre_start_out", k, 16'(o[k]), 1);
        if (nw == 2)
            d[k] = w1;
        else
            v[k] = 1'b0;
        for (int i = 0; i < nbits * 4; i++) begin
            @(negedge CLK);
            if (i == 0)
                v[k] = 1'b0;
            if (i % 4 == 1)
                chk("frame_bit", k, 16'(o[k]), int'(bits[i / 4]));
        end
        @(negedge CLK);
        chk("end_busy", k, 16'(bsy[k]), 0);
        chk("end_out", k, 16'(o[k]), 1);
    endtask

    task automatic fifo_burst();
        logic [8:0] w [6] = '{9'h11, 9'h22, 9'h33, 9'h44, 9'h55, 9'h66};
        @(negedge CLK);
        d[0] = w[0];
        v[0] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge CLK);
            if (i == 1)
                chk("lvl_before_pop", 0, 16'(lv0), 1);
            if (i == 2)
                chk("lvl_after_pop", 0, 16'(lv0), 1);
            if (i == 5) begin
                chk("full_level", 0, 16'(lv0), 4);
                chk("full_ready", 0, 16'(rdy[0]), 0);
            end
            d[0] = w[i];
        end
        @(negedge CLK);
        v[0] = 1'b0;
        chk("drop_level", 0, 16'(lv0), 4);
        repeat (195) @(negedge CLK);
        chk("burst_busy", 0, 16'(bsy[0]), 1);
        @(negedge CLK);
        chk("burst_done_busy", 0, 16'(bsy[0]), 0);
        chk("burst_done_out", 0, 16'(o[0]), 1);
    endtask

    task automatic reset_mid_frame();
        @(negedge CLK);
        d[0] = 9'hA1;
        v[0] = 1'b1;
        @(negedge CLK);
        d[0] = 9'hB2;
        @(negedge CLK);
        d[0] = 9'hC3;
        @(negedge CLK);
        v[0] = 1'b0;
        repeat (12) @(negedge CLK);
        chk("mid_level", 0, 16'(lv0), 2);
        chk("mid_data2", 0, 16'(o[0]), 0);
        #1 RST = 1'b1;
        #1;
        chk("rst_out", 0, 16'(o[0]), 1);
        chk("rst_level", 0, 16'(lv0), 0);
        chk("rst_ready", 0, 16'(rdy[0]), 1);
        chk("rst_busy", 0, 16'(bsy[0]), 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (60) @(negedge CLK);
        chk("post_rst_busy", 0, 16'(bsy[0]), 0);
        chk("post_rst_out", 0, 16'(o[0]), 1);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        for (int k = 0; k < 4; k++) begin
            chk("rst_init_out", k, 16'(o[k]), 1);
            chk("rst_init_ready", k, 16'(rdy[k]), 1);
            chk("rst_init_busy", k, 16'(bsy[k]), 0);
            chk("rst_init_level", k, 16'(lvl(k)), 0);
        end
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        pin_frame(0, 1, 9'h55, 9'h00, 16'h02AA, 10);
        pin_frame(1, 1, 9'hA5, 9'h00, 16'h0D4A, 12);
        pin_frame(2, 1, 9'hA5, 9'h00, 16'h0F4A, 12);
        pin_frame(3, 2, 9'h1F, 9'h00, 16'h207E, 14);
        fifo_burst();
        reset_mid_frame();

        repeat (2500) begin
            @(negedge CLK);
            for (int k = 0; k < 4; k++) begin
                v[k] = ($urandom_range(0, 9) == 0);
                d[k] = 9'($urandom_range(0, 511));
            end
        end
        repeat (600) begin
            @(negedge CLK);
            v = {3'b000, 1'($urandom_range(0, 1))};
            d[0] = 9'($urandom_range(0, 511));
        end
        @(negedge CLK);
        v = '0;
        repeat (1000) @(negedge CLK);
        for (int k = 0; k < 4; k++)
            chk("drain_busy", k, 16'(bsy[k]), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter; successor to the single-byte 8N1 sender.
- Adds configurable data width, parity mode and stop-bit count.
- Adds an internal transmit FIFO so the host can queue several words, and frames go out back-to-back with no idle gap.
- Sits between the core's output/MMIO path and the board TX pin.

Parameters:
- COUNT_WIDTH, 12, width of the baud counter.
- COUNT_MAX, 12'd2603, baud counter terminal value; one bit time = COUNT_MAX+1 cycles (300 MHz / 115200).
- DATA_BITS, 8, data bits per frame (5..9), sent LSB first.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame (1 or 2).
- FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW words.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- in  input  DATA_BITS  word to transmit.
- valid  input  1  in is valid.
- ready  output  1  FIFO can accept a word (= not full).
- out  output  1  serial TX line, idle high.
- busy  output  1  frame in progress or FIFO non-empty.
- level  output  FIFO_AW+1  number of words queued (excludes the frame being shifted).

Behaviour:
- Reset (RST high, async):
  - FIFO empty, level=0, FSM=IDLE, baud counter=0, shift register=0.
  - Outputs: out=1, ready=1, busy=0.
- Push: word accepted on a rising edge where valid && ready; written at the write pointer, level+1.
- ready = !full, a pure function of registered FIFO state. A pop in the same cycle does not make a full FIFO accept a push.
- valid while full: ignored; the word is dropped and nothing changes.
- Pointers: FIFO_AW+1 bits with a wrap bit.
  - full = pointers equal except the MSB.
  - empty = pointers equal.
  - Pointers wrap modulo 2^(FIFO_AW+1).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- out decode (combinational from registered state): IDLE 1, START 0, DATA shift[0], PARITY parity bit, STOP 1.
- IDLE:
  - If the FIFO is non-empty at an edge: pop the head into the shift register, compute parity, clear the counter, go to START.
  - out goes low immediately after that edge.
  - A word pushed into an empty FIFO at edge t is popped at edge t+1.
- Bit timing: counter increments every cycle outside IDLE. At COUNT_MAX it resets to 0 and the FSM advances one bit.
- DATA: shift right once per bit; after DATA_BITS bits go to PARITY if PARITY!=0, else STOP.
- Parity value:
  - even: XOR of the data bits.
  - odd: inverted XOR of the data bits.
  - Computed from the word at pop time.
- STOP: lasts STOP_BITS bit times. At the end of the last stop bit:
  - FIFO non-empty: pop and go directly to START on the same edge (no idle cycle).
  - otherwise go to IDLE.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * (COUNT_MAX+1) cycles.
- Simultaneous push and pop (not full): level unchanged, both pointers advance.
  - Push into an empty FIFO while the FSM is popping: the pop sees the empty state, the word waits until the next pop opportunity.
- Reset mid-frame: out returns to 1 asynchronously and queued words are discarded.
- busy = (FSM != IDLE) || !empty.

Test Plan:
- Defaults overridden with COUNT_MAX=3 (4 cycles/bit), 8N1.
  - Push 0x55 at edge t -> out low from edge t+1.
  - Bit sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles.
  - out=1 and busy=0 after 40 cycles.
- PARITY=2, then PARITY=1, STOP_BITS=2; push 0xA5:
  - data 1,0,1,0,0,1,0,1.
  - parity 0 (even) / 1 (odd).
  - two stop bits; frame = 48 cycles.
- FIFO_AW=2:
  - Push 5 words back-to-back -> first popped immediately; level reaches 4; ready=0.
  - A 6th valid is dropped.
  - All 5 frames emitted contiguously with no idle cycle between stop and start.
- DATA_BITS=5, send 0x1F then 0x00 -> frames 0,1,1,1,1,1,1 and 0,0,0,0,0,0,1 (7 bits, 28 cycles each).
- Assert RST during the 3rd data bit with 2 words queued -> out=1 within the same cycle, level=0, ready=1, busy=0; no further frames after release.
- Pointer wrap: push and drain 20 words through a depth-4 FIFO -> data order preserved, level never exceeds 4.
